// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Default constants and helper function shared by the
//             programmable sequence detector and its match counter.
//  Contents : c_DEF_MAX_LEN, c_DEF_CNT_W, c_DEF_RST_PAT, c_DEF_RST_LEN,
//             len_width() - width needed to hold a length 0..max_len.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

   localparam int         c_DEF_MAX_LEN = 8;
   localparam int         c_DEF_CNT_W   = 16;
   localparam logic [7:0] c_DEF_RST_PAT = 8'b0001_1011;
   localparam int         c_DEF_RST_LEN = 5;

   // Bits needed to represent every length from 0 up to and including max_len.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its all-ones value.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset, clears the count
//             inc  - increment enable
//             cnt  - current count (WIDTH bits)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_prog
//  Purpose  : Programmable serial pattern detector (Mealy) with overlapping /
//             non-overlapping modes and a saturating match counter.
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             y         - serial data bit
//             in_valid  - y is sampled only when high
//             cfg_load  - one-cycle pulse latching pat / pat_len / overlap
//             pat       - pattern, pat[pat_len-1] is received first
//             pat_len   - pattern length (legal 2..MAX_LEN)
//             overlap   - 1 = overlapping, 0 = non-overlapping detection
//             z         - combinational match, same cycle as the last bit
//             z_q       - z registered by one clock
//             match_cnt - saturating number of matches
//             cfg_err   - latched pattern length is illegal
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN = c_DEF_MAX_LEN,
   parameter int                 CNT_W   = c_DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(c_DEF_RST_PAT),
   parameter int                 RST_LEN = c_DEF_RST_LEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             y,
   input  logic                             in_valid,
   input  logic                             cfg_load,
   input  logic [MAX_LEN-1:0]               pat,
   input  logic [len_width(MAX_LEN)-1:0]    pat_len,
   input  logic                             overlap,
   output logic                             z,
   output logic                             z_q,
   output logic [CNT_W-1:0]                 match_cnt,
   output logic                             cfg_err
);

   localparam int c_LW = len_width(MAX_LEN);

   logic [MAX_LEN-1:0] r_hist;
   logic [c_LW-1:0]    r_fill;
   logic [MAX_LEN-1:0] r_cfg_pat;
   logic [c_LW-1:0]    r_cfg_len;
   logic               r_cfg_ovl;
   logic               r_cfg_err;
   logic               r_z_q;

   logic [MAX_LEN:0]   w_win;
   logic [MAX_LEN:0]   w_mask;
   logic               w_bits_eq;
   logic               w_fill_ok;
   logic               w_len_bad;
   logic [c_LW-1:0]    w_fill_inc;
   logic               w_z;

   // Current bit joins the history so the last pattern bit can match
   // in the same cycle it arrives.
   assign w_win = {r_hist, y};

   // Select only the newest cfg_len bits of the window for comparison.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
         if (i < int'(r_cfg_len)) begin
            w_mask[i] = 1'b1;
         end
      end
   end

   assign w_bits_eq = (((w_win ^ {1'b0, r_cfg_pat}) & w_mask) == '0);

   // fill counts bits eligible to be part of a match; the incoming bit
   // supplies one more, hence fill + 1 >= cfg_len.
   assign w_fill_ok  = (({1'b0, r_fill} + (c_LW + 1)'(1)) >= {1'b0, r_cfg_len});

   assign w_fill_inc = (r_fill == c_LW'(MAX_LEN)) ? r_fill : (r_fill + c_LW'(1));

   assign w_len_bad  = (pat_len < c_LW'(2)) || (int'(pat_len) > MAX_LEN);

   assign w_z = ~rst & in_valid & ~cfg_load & ~r_cfg_err & w_fill_ok & w_bits_eq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_cfg_pat <= RST_PAT;
         r_cfg_len <= c_LW'(RST_LEN);
         r_cfg_ovl <= 1'b1;
         r_cfg_err <= 1'b0;
         r_z_q     <= 1'b0;
      end else begin
         r_z_q <= w_z;
         if (cfg_load) begin
            // Loading a new pattern discards any partial match; y is ignored.
            r_cfg_pat <= pat;
            r_cfg_len <= pat_len;
            r_cfg_ovl <= overlap;
            r_cfg_err <= w_len_bad;
            r_fill    <= '0;
         end else if (in_valid) begin
            r_hist <= {r_hist[MAX_LEN-2:0], y};
            // Non-overlapping mode: bits consumed by a match cannot be reused.
            r_fill <= (w_z && !r_cfg_ovl) ? '0 : w_fill_inc;
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_z),
      .cnt (match_cnt)
   );

   assign z       = w_z;
   assign z_q     = r_z_q;
   assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire
